imem_fetch_responder: RTL and testbench

//  Instruction-memory responder: the memory end of the core's fetch interface.

---
 rtl/imem_fetch_responder.sv | 111 +++++++++++
 tb/tb_imem_fetch_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder for the core fetch port: one request in flight,
// programmable wait states, word array preloaded through a dedicated init port.
module imem_fetch_responder #(
    parameter int unsigned           WIDTH      = 64,
    parameter int unsigned           INST_WIDTH = 32,
    parameter int unsigned           DEPTH_LOG2 = 12,
    parameter logic [WIDTH-1:0]      BASE_ADDR  = 'h8000_0000,
    parameter int unsigned           LATENCY    = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [WIDTH-1:0]       req_addr_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [INST_WIDTH-1:0]  rsp_inst_o,
    output logic                   rsp_err_o,
    input  logic                   init_we_i,
    input  logic [DEPTH_LOG2-1:0]  init_addr_i,
    input  logic [INST_WIDTH-1:0]  init_data_i
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [WIDTH-1:0]       addr_q;
    logic [INST_WIDTH-1:0]  inst_q;
    logic                   err_q;
    logic [INST_WIDTH-1:0]  mem_q [DEPTH];

    logic                   accept;
    logic                   enter_resp;
    logic [WIDTH-1:0]       rd_addr;
    logic [WIDTH-1:0]       word_off;
    logic [DEPTH_LOG2-1:0]  idx;
    logic                   fault;

    assign accept     = req_valid_i && (state_q == S_IDLE);
    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

    // With zero wait states the read happens on the accept edge, before addr_q is loaded.
    assign rd_addr  = (state_q == S_IDLE) ? req_addr_i : addr_q;
    assign word_off = (rd_addr - BASE_ADDR) >> 2;
    assign idx      = word_off[DEPTH_LOG2-1:0];
    assign fault    = (|rd_addr[1:0]) || (rd_addr < BASE_ADDR) || (|word_off[WIDTH-1:DEPTH_LOG2]);

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = 4'(LATENCY);
                    state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready_o = (state_q == S_IDLE);
        rsp_valid_o = (state_q == S_RESP);
        rsp_inst_o  = inst_q;
        rsp_err_o   = err_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            addr_q <= '0;
            inst_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) addr_q <= req_addr_i;
            if (enter_resp) begin
                err_q  <= fault;
                inst_q <= fault ? '0 : mem_q[idx];
            end
        end
    end

    // Preload port stays live through reset; reads see the pre-edge contents.
    always_ff @(posedge clk_i) begin
        if (init_we_i) mem_q[init_addr_i] <= init_data_i;
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboarded bench: three responders (LATENCY 1, 0, 3) share a preloaded image;
// a reference model predicts every fetch and a monitor checks what comes back.
module tb_imem_fetch_responder;

    localparam int          NI    = 3;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          DEPTH = 4096;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NI-1:0]     req_valid, req_ready, rsp_valid, rsp_err;
    logic [63:0]       req_addr;
    logic              rsp_ready;
    logic [31:0]       rsp_inst [NI];
    logic              init_we;
    logic [11:0]       init_addr;
    logic [31:0]       init_data;

    int lat [NI] = '{1, 0, 3};

    typedef struct {
        int          id;
        logic [31:0] inst;
        logic        err;
        int          first;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mdl [DEPTH];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;
    bit          rand_rdy = 0;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    for (genvar g = 0; g < NI; g++) begin : g_dut
        imem_fetch_responder #(.LATENCY(g == 0 ? 1 : (g == 1 ? 0 : 3))) u_dut (
            .clk_i       (clk),
            .rst_n_i     (rst_n),
            .req_valid_i (req_valid[g]),
            .req_ready_o (req_ready[g]),
            .req_addr_i  (req_addr),
            .rsp_valid_o (rsp_valid[g]),
            .rsp_ready_i (rsp_ready),
            .rsp_inst_o  (rsp_inst[g]),
            .rsp_err_o   (rsp_err[g]),
            .init_we_i   (init_we),
            .init_addr_i (init_addr),
            .init_data_i (init_data)
        );
    end

    task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, g, act, exp);
        end
    endtask

    // Reference: byte address -> word index, fault on misalignment or outside the window.
    function automatic exp_t predict(input int g, input logic [63:0] a);
        exp_t        e;
        logic [63:0] off;
        off    = a - BASE;
        e.id   = g;
        e.err  = (a % 4 != 0) || (a < BASE) || (off / 4 >= DEPTH);
        e.inst = e.err ? 32'h0 : mdl[off / 4];
        e.first = 0;
        return e;
    endfunction

    task automatic wait_idle(input int g);
        int n = 0;
        while (!req_ready[g] && n < 200) begin @(posedge clk); #1; n++; end
        if (!req_ready[g]) begin
            n_checks++; n_err++;
            $display("FAIL idle_timeout dut%0d: got busy expected ready", g);
        end
    endtask

    task automatic fetch(input int g, input logic [63:0] a);
        exp_t e;
        wait_idle(g);
        req_addr     = a;
        req_valid[g] = 1'b1;
        @(posedge clk); #1;
        req_valid[g] = 1'b0;
        e       = predict(g, a);
        e.first = cyc + lat[g];
        sb.push_back(e);
    endtask

    task automatic backpressure(input int g, input logic [63:0] a);
        int n = 0;
        rsp_ready = 1'b0;
        fetch(g, a);
        while (!rsp_valid[g] && n < 50) begin @(posedge clk); #1; n++; end
        if (!rsp_valid[g]) begin
            n_checks++; n_err++;
            $display("FAIL rsp_timeout dut%0d: got no rsp_valid expected rsp_valid", g);
        end
        repeat (5) @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_idle(g);
    endtask

    // Monitor: compares whatever is presented against the scoreboard head every cycle.
    initial begin
        bit pv [NI];
        bit ic [NI];
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int g = 0; g < NI; g++) begin pv[g] = 0; ic[g] = 0; end
            end else begin
                for (int g = 0; g < NI; g++) begin
                    if (ic[g]) begin
                        chk("idle_after_handshake", g, {req_ready[g], rsp_valid[g]}, 2'b10);
                        ic[g] = 0;
                    end
                    if (rsp_valid[g]) begin
                        chk("req_ready_in_resp", g, req_ready[g], 1'b0);
                        if (sb.size() == 0 || sb[0].id != g) begin
                            n_checks++; n_err++;
                            $display("FAIL unexpected_rsp dut%0d: got rsp_valid inst %h expected none", g, rsp_inst[g]);
                        end else begin
                            chk("rsp_inst", g, rsp_inst[g], sb[0].inst);
                            chk("rsp_err", g, rsp_err[g], sb[0].err);
                            if (!pv[g]) chk("latency_cycle", g, cyc, sb[0].first);
                            if (rsp_ready) begin
                                void'(sb.pop_front());
                                ic[g] = 1;
                            end
                        end
                    end
                    pv[g] = rsp_valid[g];
                end
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        exp_t drop;
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        rsp_ready = 1'b1;
        init_we   = 1'b0;
        init_addr = '0;
        init_data = '0;
        @(posedge clk); #1;

        // Whole image loaded while reset is held.
        for (int i = 0; i < DEPTH; i++) begin
            mdl[i]    = (i == 0) ? 32'h0000_0413 : (i == 1) ? 32'h0080_0513 : $urandom;
            init_we   = 1'b1;
            init_addr = 12'(i);
            init_data = mdl[i];
            @(posedge clk); #1;
        end
        init_we = 1'b0;
        rst_n   = 1'b1;

        for (int g = 0; g < NI; g++) begin
            chk("reset_req_ready", g, req_ready[g], 1'b1);
            chk("reset_rsp_valid", g, rsp_valid[g], 1'b0);
            chk("reset_rsp_inst", g, rsp_inst[g], 32'h0);
            chk("reset_rsp_err", g, rsp_err[g], 1'b0);
        end

        fetch(0, BASE);                  wait_idle(0);
        fetch(1, BASE + 4);              wait_idle(1);
        fetch(1, BASE + 2);              wait_idle(1);
        fetch(0, 64'h7FFF_FFFC);         wait_idle(0);
        fetch(2, 64'h8000_4000);         wait_idle(2);
        fetch(0, BASE + 4 * 4095);       wait_idle(0);
        fetch(2, BASE + 12);             wait_idle(2);

        backpressure(0, BASE + 20);
        backpressure(1, BASE + 3);
        backpressure(2, BASE + 24);

        // Reset lands while the LATENCY=3 responder is still waiting.
        fetch(2, BASE + 16);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drop = sb.pop_back();
        chk("midwait_reset_req_ready", 2, req_ready[2], 1'b1);
        chk("midwait_reset_rsp_valid", 2, rsp_valid[2], 1'b0);
        chk("midwait_reset_rsp_inst", 2, rsp_inst[2], 32'h0);
        chk("midwait_reset_rsp_err", 2, rsp_err[2], 1'b0);
        repeat (10) @(posedge clk);
        #1;

        // Init write of word 2 on the same edge that enters RESP.
        fetch(0, BASE + 8);
        init_we   = 1'b1;
        init_addr = 12'd2;
        init_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        init_we = 1'b0;
        mdl[2]  = 32'hDEAD_BEEF;
        wait_idle(0);
        fetch(0, BASE + 8);              wait_idle(0);
        fetch(1, BASE + 8);              wait_idle(1);

        rand_rdy = 1;
        for (int t = 0; t < 90; t++) begin
            int          g;
            int unsigned k;
            logic [63:0] a;
            g = $urandom_range(0, NI - 1);
            k = $urandom_range(0, DEPTH - 1);
            case ($urandom_range(0, 9))
                0:       a = BASE + 4 * k + $urandom_range(1, 3);
                1:       a = BASE - 4 * $urandom_range(1, 1000);
                2:       a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 1000);
                3:       a = BASE + 4 * (DEPTH - 1);
                default: a = BASE + 4 * k;
            endcase
            fetch(g, a);
            wait_idle(g);
        end
        rand_rdy  = 0;
        rsp_ready = 1'b1;
        for (int g = 0; g < NI; g++) wait_idle(g);
        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", 0, sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
